// File: rtl/pmp_csr_file.sv
// pmp_csr_file: machine-mode CSR owner of the PMP state (pmpcfg0, pmpaddr0..N-1).
// Accepts CSR read/write requests through a single-entry response buffer, applies
// WARL and lock legalisation, and drives the per-entry cfg/addr buses for the checker.
//
// Optional feature macro: PMP_DBG_UNLOCK_EN adds dbg_mode, which bypasses all lock
// checks for requests accepted while it is high (L bits may then be cleared).
//
// Ports:
//   clock, reset_n          block clock, asynchronous active-low reset
//   req_valid/req_ready     request handshake (req_ready = !resp_valid | resp_ready)
//   req_write/addr/wdata    CSR number, write flag and write data
//   resp_valid/resp_ready   response handshake, response held until consumed
//   resp_rdata/resp_err     pre-write CSR value, illegal-CSR flag
//   pmp_cfg/pmp_addr        registered per-entry configuration and address buses
//   cfg_changed             one-cycle pulse when a write changed stored state
module pmp_csr_file #(
  parameter int unsigned NUM_ENTRIES = 4,
  parameter int unsigned ADDR_W      = 30
) (
  input  logic                          clock,
  input  logic                          reset_n,
`ifdef PMP_DBG_UNLOCK_EN
  input  logic                          dbg_mode,
`endif
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic                          req_write,
  input  logic [11:0]                   req_addr,
  input  logic [31:0]                   req_wdata,
  output logic                          resp_valid,
  input  logic                          resp_ready,
  output logic [31:0]                   resp_rdata,
  output logic                          resp_err,
  output logic [8*NUM_ENTRIES-1:0]      pmp_cfg,
  output logic [ADDR_W*NUM_ENTRIES-1:0] pmp_addr,
  output logic                          cfg_changed
);

  localparam logic [11:0] CSR_PMPCFG0  = 12'h3A0;
  localparam logic [11:0] CSR_CFG_LAST = 12'h3A3;
  localparam logic [11:0] CSR_PMPADDR0 = 12'h3B0;
  localparam logic [1:0]  A_TOR        = 2'b01;

  logic [NUM_ENTRIES-1:0][7:0]        cfg_q, cfg_d;
  logic [NUM_ENTRIES-1:0][ADDR_W-1:0] addr_q, addr_d;
  logic                               resp_valid_d, resp_err_d, cfg_changed_d;
  logic [31:0]                        resp_rdata_d, rd_value;
  logic [NUM_ENTRIES:0]               tor_lock;
  logic                               accept, known, lock_bypass;
  logic                               unused_wdata;

`ifdef PMP_DBG_UNLOCK_EN
  assign lock_bypass = dbg_mode;
`else
  assign lock_bypass = 1'b0;
`endif

  assign req_ready    = !resp_valid || resp_ready;
  assign accept       = req_valid && req_ready;
  assign pmp_cfg      = cfg_q;
  assign pmp_addr     = addr_q;
  // Bits 6:5 of each cfg byte and bytes beyond NUM_ENTRIES are discarded by design.
  assign unused_wdata = ^req_wdata;

  // Mapped range: pmpcfg0..3 (only pmpcfg0 backed) and the whole pmpaddr0..15 block.
  assign known = ((req_addr >= CSR_PMPCFG0) && (req_addr <= CSR_CFG_LAST)) ||
                 (req_addr[11:4] == CSR_PMPADDR0[11:4]);

  // Entry i locked with A=TOR also freezes pmpaddr i-1 (its lower bound).
  always_comb begin
    tor_lock = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      tor_lock[i] = cfg_q[i][7] && (cfg_q[i][4:3] == A_TOR);
    end
  end

  // Pre-write read value of the addressed CSR; unbacked CSRs read 0.
  always_comb begin
    rd_value = '0;
    if (req_addr == CSR_PMPCFG0) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        rd_value[8*i +: 8] = cfg_q[i];
      end
    end
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (req_addr == CSR_PMPADDR0 + 12'(i)) begin
        rd_value = 32'(addr_q[i]);
      end
    end
  end

  // Next state: response buffer, legalised writes and change detection.
  always_comb begin
    cfg_d         = cfg_q;
    addr_d        = addr_q;
    resp_valid_d  = resp_valid;
    resp_rdata_d  = resp_rdata;
    resp_err_d    = resp_err;
    cfg_changed_d = 1'b0;
    if (accept) begin
      resp_valid_d = 1'b1;
      resp_err_d   = !known;
      resp_rdata_d = known ? rd_value : 32'h0;
      if (req_write && known) begin
        for (int i = 0; i < NUM_ENTRIES; i++) begin
          // WARL: bits 6:5 forced 0, W=1/R=0 collapses to W=0.
          if ((req_addr == CSR_PMPCFG0) && (lock_bypass || !cfg_q[i][7])) begin
            cfg_d[i] = {req_wdata[8*i+7], 2'b00, req_wdata[8*i+3 +: 2],
                        req_wdata[8*i+2], req_wdata[8*i+1] & req_wdata[8*i],
                        req_wdata[8*i]};
          end
          if ((req_addr == CSR_PMPADDR0 + 12'(i)) &&
              (lock_bypass || !(cfg_q[i][7] || tor_lock[i+1]))) begin
            addr_d[i] = req_wdata[ADDR_W-1:0];
          end
        end
        cfg_changed_d = (cfg_d != cfg_q) || (addr_d != addr_q);
      end
    end else if (resp_ready) begin
      resp_valid_d = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cfg_q       <= '0;
      addr_q      <= '0;
      resp_valid  <= 1'b0;
      resp_rdata  <= '0;
      resp_err    <= 1'b0;
      cfg_changed <= 1'b0;
    end else begin
      cfg_q       <= cfg_d;
      addr_q      <= addr_d;
      resp_valid  <= resp_valid_d;
      resp_rdata  <= resp_rdata_d;
      resp_err    <= resp_err_d;
      cfg_changed <= cfg_changed_d;
    end
  end

endmodule

// File: tb/tb_pmp_csr_file.sv
// tb_pmp_csr_file: directed and randomized bench for pmp_csr_file, checked every
// cycle against a behavioural CSR model plus literal expectations for key scenarios.
module tb_pmp_csr_file;

  localparam int N  = 4;
  localparam int AW = 30;

  logic            clock, reset_n;
  logic            req_valid, req_ready, req_write;
  logic [11:0]     req_addr;
  logic [31:0]     req_wdata;
  logic            resp_valid, resp_ready, resp_err, cfg_changed;
  logic [31:0]     resp_rdata;
  logic [8*N-1:0]  pmp_cfg;
  logic [AW*N-1:0] pmp_addr;

  int tests = 0;
  int fails = 0;

  pmp_csr_file #(.NUM_ENTRIES(N), .ADDR_W(AW)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
`ifdef PMP_DBG_UNLOCK_EN
    .dbg_mode   (1'b0),
`endif
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .pmp_cfg    (pmp_cfg),
    .pmp_addr   (pmp_addr),
    .cfg_changed(cfg_changed)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0]    m_cfg  [N];
  logic [AW-1:0] m_addr [N];
  logic          e_valid, e_err, e_chg;
  logic [31:0]   e_rdata;

  task automatic model_req(input logic w, input logic [11:0] a, input logic [31:0] d);
    logic [31:0] rd;
    logic [7:0]  nb;
    bit          err, chg, locked;
    int          idx;
    rd = 32'h0; err = 0; chg = 0; idx = 0;
    if (a == 12'h3A0) begin
      for (int i = 0; i < N; i++) rd[8*i +: 8] = m_cfg[i];
    end else if (a inside {[12'h3A1:12'h3A3]}) begin
      rd = 32'h0;
    end else if (a[11:4] == 8'h3B) begin
      idx = int'(a[3:0]);
      if (idx < N) rd = 32'(m_addr[idx]);
    end else begin
      err = 1;
    end
    if (w && !err) begin
      if (a == 12'h3A0) begin
        for (int i = 0; i < N; i++) begin
          if (m_cfg[i][7] == 1'b0) begin
            nb = d[8*i +: 8] & 8'h9F;
            if (nb[1] && !nb[0]) nb[1] = 1'b0;
            if (nb != m_cfg[i]) chg = 1;
            m_cfg[i] = nb;
          end
        end
      end else if (a[11:4] == 8'h3B && idx < N) begin
        locked = m_cfg[idx][7];
        if (idx + 1 < N) locked = locked || (m_cfg[idx+1][7] && m_cfg[idx+1][4:3] == 2'b01);
        if (!locked && m_addr[idx] != d[AW-1:0]) begin
          chg = 1;
          m_addr[idx] = d[AW-1:0];
        end
      end
    end
    e_valid = 1; e_rdata = rd; e_err = err; e_chg = chg;
  endtask

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N; i++) begin m_cfg[i] = 8'h0; m_addr[i] = '0; end
      e_valid = 0; e_err = 0; e_chg = 0; e_rdata = 32'h0;
    end else begin
      e_chg = 0;
      if (req_valid && (!e_valid || resp_ready)) model_req(req_write, req_addr, req_wdata);
      else if (resp_ready) e_valid = 0;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clock) begin
    logic [8*N-1:0]  exp_cfg;
    logic [AW*N-1:0] exp_addr;
    if (reset_n) begin
      for (int i = 0; i < N; i++) begin
        exp_cfg[8*i +: 8]   = m_cfg[i];
        exp_addr[AW*i +: AW] = m_addr[i];
      end
      check("req_ready", 128'(req_ready), 128'(!e_valid || resp_ready));
      check("resp_valid", 128'(resp_valid), 128'(e_valid));
      check("cfg_changed", 128'(cfg_changed), 128'(e_chg));
      check("pmp_cfg", 128'(pmp_cfg), 128'(exp_cfg));
      check("pmp_addr", 128'(pmp_addr), 128'(exp_addr));
      if (e_valid) begin
        check("resp_rdata", 128'(resp_rdata), 128'(e_rdata));
        check("resp_err", 128'(resp_err), 128'(e_err));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input logic w, input logic [11:0] a, input logic [31:0] d);
    int n;
    n = 0;
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
    #1;
    while (!req_ready && n < 50) begin
      @(negedge clock); #1;
      n++;
    end
    if (n >= 50) begin
      fails++; tests++;
      $display("FAIL send_timeout: addr %h never accepted", a);
    end
    @(negedge clock); #1;
    req_valid = 1'b0;
  endtask

  task automatic idle(input int cycles);
    req_valid = 1'b0;
    repeat (cycles) begin @(negedge clock); #1; end
  endtask

  function automatic logic [11:0] pick_addr();
    case ($urandom_range(0, 7))
      0, 1:    return 12'h3A0;
      2, 3:    return 12'h3B0 + 12'($urandom_range(0, 3));
      4:       return 12'h3A1 + 12'($urandom_range(0, 2));
      5:       return 12'h3B4 + 12'($urandom_range(0, 11));
      6:       return ($urandom_range(0, 1) == 0) ? 12'h7C0 : 12'h3A4;
      default: return 12'($urandom);
    endcase
  endfunction

  initial begin
    bit acc;
    req_valid = 0; req_write = 0; req_addr = 0; req_wdata = 0;
    resp_ready = 1; reset_n = 0;
    repeat (3) @(negedge clock);
    #1 reset_n = 1;
    check("rst_pmp_cfg", 128'(pmp_cfg), 128'h0);
    check("rst_resp_valid", 128'(resp_valid), 128'h0);

    send(0, 12'h3A0, 32'h0);
    check("rd_cfg_rst", 128'(resp_rdata), 128'h0);
    send(0, 12'h3B0, 32'h0);
    check("rd_addr_rst", 128'(resp_rdata), 128'h0);
    check("rd_no_change", 128'(cfg_changed), 128'h0);

    send(1, 12'h3A0, 32'h0000_1F62);
    check("warl_rdata", 128'(resp_rdata), 128'h0);
    check("warl_changed", 128'(cfg_changed), 128'h1);
    check("warl_cfg", 128'(pmp_cfg), 128'h0000_1F00);
    idle(1);
    check("changed_pulse", 128'(cfg_changed), 128'h0);

    send(1, 12'h3B1, 32'h00AB_CDEF);
    send(1, 12'h3B0, 32'h2000_0000);
    check("addr0_write", 128'(pmp_addr[AW-1:0]), 128'h2000_0000);
    send(1, 12'h3A0, 32'h0000_8F00);
    check("lock_rdata", 128'(resp_rdata), 128'h0000_1F00);
    check("lock_cfg", 128'(pmp_cfg), 128'h0000_8F00);
    send(1, 12'h3B0, 32'h0000_1234);
    check("tor_rdata", 128'(resp_rdata), 128'h2000_0000);
    check("tor_no_change", 128'(cfg_changed), 128'h0);
    check("tor_addr0", 128'(pmp_addr[AW-1:0]), 128'h2000_0000);
    send(1, 12'h3A0, 32'h1D0B_0009);
    check("partial_cfg", 128'(pmp_cfg), 128'h1D0B_8F09);
    send(1, 12'h3A0, 32'h0);
    check("clear_rdata", 128'(resp_rdata), 128'h1D0B_8F09);
    check("clear_cfg", 128'(pmp_cfg), 128'h0000_8F00);
    check("clear_changed", 128'(cfg_changed), 128'h1);

    idle(1);
    resp_ready = 0;
    send(0, 12'h3B1, 32'h0);
    req_valid = 1; req_write = 0; req_addr = 12'h3A0; req_wdata = 32'h0;
    repeat (3) begin
      #1;
      check("stall_ready", 128'(req_ready), 128'h0);
      check("stall_valid", 128'(resp_valid), 128'h1);
      check("stall_rdata", 128'(resp_rdata), 128'h00AB_CDEF);
      @(negedge clock); #1;
    end
    resp_ready = 1;
    #1 check("release_ready", 128'(req_ready), 128'h1);
    @(negedge clock); #1;
    req_valid = 0;
    check("queued_rdata", 128'(resp_rdata), 128'h0000_8F00);

    idle(1);
    resp_ready = 0;
    send(0, 12'h7C0, 32'h0);
    check("err_flag", 128'(resp_err), 128'h1);
    check("err_rdata", 128'(resp_rdata), 128'h0);
    check("err_cfg", 128'(pmp_cfg), 128'h0000_8F00);
    #2 reset_n = 0;
    #1 check("async_drop", 128'(resp_valid), 128'h0);
    check("async_cfg", 128'(pmp_cfg), 128'h0);
    @(negedge clock); #1;
    reset_n = 1; resp_ready = 1;

    acc = 0;
    for (int k = 0; k < 800; k++) begin
      if (k == 400) begin
        req_valid = 0; reset_n = 0; #1 reset_n = 1;
        acc = 0;
      end
      if (!req_valid || acc) begin
        if ($urandom_range(0, 9) < 7) begin
          req_valid = 1;
          req_write = 1'($urandom_range(0, 1));
          req_addr  = pick_addr();
          req_wdata = $urandom;
          if ($urandom_range(0, 7) != 0) req_wdata = req_wdata & 32'h7F7F_7F7F;
        end else begin
          req_valid = 0;
        end
      end
      resp_ready = ($urandom_range(0, 3) != 0);
      #1 acc = req_valid && req_ready;
      @(negedge clock); #1;
    end
    idle(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
